// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: RV32I load/store funct3
// codes and the arbitration state encoding.
package dmem_arbiter_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_PRI0  = 2'd0,
    ST_PRI1  = 2'd1,
    ST_LOCK0 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_access_check.sv
// Combinational legality check of a load/store: funct3 must be valid for the
// direction and the address must be naturally aligned for the access size.
module dmem_access_check
  import dmem_arbiter_pkg::*;
(
  input  logic       we_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_lo_i,
  output logic       legal_o
);

  always_comb begin
    legal_o = 1'b0;
    case (funct3_i)
      F3_B:    legal_o = 1'b1;
      F3_H:    legal_o = ~addr_lo_i[0];
      F3_W:    legal_o = (addr_lo_i == 2'b00);
      F3_BU:   legal_o = ~we_i;
      F3_HU:   legal_o = ~we_i & ~addr_lo_i[0];
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter with a bounded requester-0 lock in front
// of a single-port data memory; loads and errors return as registered pulses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [2:0]            r0_funct3,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic                  r0_lock,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_err,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [2:0]            r1_funct3,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_err,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam logic [4:0] LOCK_MAX_W = 5'(LOCK_MAX);

  arb_state_e      state_q, state_d;
  logic [3:0]      lock_cnt_q, lock_cnt_d;
  logic [4:0]      cnt_inc;
  logic [1:0]      gnt_vec;
  logic            any_gnt;
  logic            sel_we;
  logic [2:0]      sel_f3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic            legal;
  logic [1:0]      rsp_fire;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    gnt_vec = 2'b00;
    case (state_q)
      ST_PRI0:  gnt_vec = {r1_req & ~r0_req, r0_req};
      ST_PRI1:  gnt_vec = {r1_req, r0_req & ~r1_req};
      ST_LOCK0: gnt_vec = {1'b0, r0_req};
      default:  gnt_vec = 2'b00;
    endcase
    if (reset) gnt_vec = 2'b00;
  end

  assign r0_gnt  = gnt_vec[0];
  assign r1_gnt  = gnt_vec[1];
  assign any_gnt = |gnt_vec;
  assign cnt_inc = {1'b0, lock_cnt_q} + 5'd1;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_PRI0, ST_PRI1: begin
        if (gnt_vec[0]) begin
          // With LOCK_MAX of 1 the entry grant already exhausts the lock.
          if (r0_lock && (LOCK_MAX > 1)) begin
            state_d    = ST_LOCK0;
            lock_cnt_d = 4'd1;
          end else begin
            state_d    = ST_PRI1;
            lock_cnt_d = 4'd0;
          end
        end else if (gnt_vec[1]) begin
          state_d = ST_PRI0;
        end
      end
      ST_LOCK0: begin
        if (gnt_vec[0] && r0_lock && (cnt_inc < LOCK_MAX_W)) begin
          lock_cnt_d = cnt_inc[3:0];
        end else begin
          state_d    = ST_PRI1;
          lock_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = ST_PRI0;
        lock_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_PRI0;
      lock_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign sel_we    = gnt_vec[1] ? r1_we     : r0_we;
  assign sel_f3    = gnt_vec[1] ? r1_funct3 : r0_funct3;
  assign sel_addr  = gnt_vec[1] ? r1_addr   : r0_addr;
  assign sel_wdata = gnt_vec[1] ? r1_wdata  : r0_wdata;

  dmem_access_check u_check (
    .we_i      (sel_we),
    .funct3_i  (sel_f3),
    .addr_lo_i (sel_addr[1:0]),
    .legal_o   (legal)
  );

  assign mem_wr_en  = any_gnt & sel_we & legal;
  assign mem_funct3 = any_gnt ? sel_f3    : 3'b000;
  assign mem_addr   = any_gnt ? sel_addr  : '0;
  assign mem_wdata  = any_gnt ? sel_wdata : '0;

  // Loads and any illegal access answer; legal stores are silent.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    assign rsp_fire[gi] = gnt_vec[gi] & (~sel_we | ~legal);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
        err_q    <= 1'b0;
      end else begin
        rvalid_q <= rsp_fire[gi];
        if (rsp_fire[gi]) begin
          rdata_q <= legal ? mem_rd_data : '0;
          err_q   <= ~legal;
        end
      end
    end
  end

  assign r0_rvalid = g_rsp[0].rvalid_q;
  assign r0_rdata  = g_rsp[0].rdata_q;
  assign r0_err    = g_rsp[0].err_q;
  assign r1_rvalid = g_rsp[1].rvalid_q;
  assign r1_rdata  = g_rsp[1].rdata_q;
  assign r1_err    = g_rsp[1].err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-addressed memory
// and per-requester response scoreboards.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we;
  logic [2:0]  r0_funct3, r1_funct3;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rd_data;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];

  logic [31:0] mem [64] = '{default: '0};
  logic [31:0] rd_word, rd_b, rd_h;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_funct3(r0_funct3), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_funct3(r1_funct3), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd_data(mem_rd_data)
  );

  // Memory: combinational read with load extension, write on the rising edge.
  always_comb begin
    rd_word = mem[mem_addr[7:2]];
    rd_b    = rd_word >> {mem_addr[1:0], 3'b000};
    rd_h    = rd_word >> {mem_addr[1], 4'b0000};
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{rd_b[7]}}, rd_b[7:0]};
      3'b001:  mem_rd_data = {{16{rd_h[15]}}, rd_h[15:0]};
      3'b100:  mem_rd_data = {24'b0, rd_b[7:0]};
      3'b101:  mem_rd_data = {16'b0, rd_h[15:0]};
      default: mem_rd_data = rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      case (mem_funct3)
        3'b000:  mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        3'b001:  mem[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[7:2]] <= mem_wdata;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (!reset) begin
      if (r0_rvalid) begin
        if (q0.size() == 0) check("r0_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("r0_rdata", r0_rdata, e.data);
          check("r0_err", {31'b0, r0_err}, {31'b0, e.err});
          $display("r0 rsp data=%h err=%0d", r0_rdata, r0_err);
        end
      end
      if (r1_rvalid) begin
        if (q1.size() == 0) check("r1_unexpected_rvalid", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("r1_rdata", r1_rdata, e.data);
          check("r1_err", {31'b0, r1_err}, {31'b0, e.err});
          $display("r1 rsp data=%h err=%0d", r1_rdata, r1_err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_req = 0; r0_we = 0; r0_funct3 = 0; r0_addr = 0; r0_wdata = 0; r0_lock = 0;
    r1_req = 0; r1_we = 0; r1_funct3 = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  task automatic drive(input int r, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (r == 0) begin
      r0_req = 1; r0_we = we; r0_funct3 = f3; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_req = 1; r1_we = we; r1_funct3 = f3; r1_addr = addr; r1_wdata = wdata;
    end
  endtask

  // One sole-requester access: granted at once, response expectation queued.
  task automatic op(input int r, input logic we, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input bit rsp, input logic [31:0] exp_data, input logic exp_err);
    drive(r, we, f3, addr, wdata);
    if (rsp) begin
      if (r == 0) q0.push_back({exp_data, exp_err});
      else        q1.push_back({exp_data, exp_err});
    end
    @(negedge clk);
    check($sformatf("r%0d_gnt_op", r), {31'b0, (r == 0) ? r0_gnt : r1_gnt}, 32'd1);
    check("mem_wr_en_op", {31'b0, mem_wr_en}, {31'b0, we & ~rsp});
    $display("op r%0d we=%0d f3=%0d addr=%h wdata=%h", r, we, f3, addr, wdata);
    tick();
    if (r == 0) r0_req = 0; else r1_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    bit exp0;
    reset = 1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
    check("rst_r1_rvalid", {31'b0, r1_rvalid}, 32'd0);
    check("rst_r0_rdata", r0_rdata, 32'd0);
    check("rst_r1_err", {31'b0, r1_err}, 32'd0);
    reset = 0;

    @(negedge clk);
    check("idle_gnt", {30'b0, r1_gnt, r0_gnt}, 32'd0);
    check("idle_mem_addr", mem_addr, 32'd0);
    check("idle_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    tick();

    // Simultaneous SW from reset: grants alternate starting with r0.
    n0 = 0; n1 = 0;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 3'b010, 32'h00, 32'hA000_0000 + n0);
      drive(1, 1, 3'b010, 32'h04, 32'hB000_0000 + n1);
      exp0 = (c % 2 == 0);
      @(negedge clk);
      check("alt_r0_gnt", {31'b0, r0_gnt}, {31'b0, exp0});
      check("alt_r1_gnt", {31'b0, r1_gnt}, {31'b0, ~exp0});
      check("alt_mem_wdata", mem_wdata, exp0 ? 32'hA000_0000 + n0 : 32'hB000_0000 + n1);
      $display("alt cycle %0d r0_gnt=%0d r1_gnt=%0d", c, r0_gnt, r1_gnt);
      tick();
      if (exp0) n0++; else n1++;
    end
    idle();
    check("alt_mem_r0", mem[0], 32'hA000_0001);
    check("alt_mem_r1", mem[1], 32'hB000_0001);

    // Store then byte load from the same word.
    op(1, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, 0, 0);
    op(1, 0, 3'b100, 32'h13, 0, 1, 32'h0000_00DE, 0);
    tick();

    // Illegal accesses and back-to-back r0 loads.
    op(0, 0, 3'b010, 32'h06, 0, 1, 32'h0, 1);
    op(0, 1, 3'b001, 32'h01, 32'hFFFF_FFFF, 1, 32'h0, 1);
    op(0, 0, 3'b010, 32'h00, 0, 1, 32'hA000_0001, 0);
    op(0, 0, 3'b000, 32'h13, 0, 1, 32'hFFFF_FFDE, 0);
    op(0, 0, 3'b001, 32'h12, 0, 1, 32'hFFFF_DEAD, 0);
    op(0, 0, 3'b101, 32'h12, 0, 1, 32'h0000_DEAD, 0);
    op(0, 0, 3'b011, 32'h00, 0, 1, 32'h0, 1);
    op(0, 1, 3'b100, 32'h00, 32'h55, 1, 32'h0, 1);
    op(0, 1, 3'b010, 32'h20, 32'h1234_5678, 0, 0, 0);
    op(0, 0, 3'b010, 32'h20, 0, 1, 32'h1234_5678, 0);
    check("mis_store_mem_unchanged", mem[0], 32'hA000_0001);
    tick();

    // Lock: r1 grant first restores PRI0, then four locked r0 grants.
    op(1, 1, 3'b010, 32'h30, 32'h1, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 3'b010, 32'h10, 0);
      r0_lock = 1;
      drive(1, 1, 3'b010, 32'h34, 32'h55);
      exp0 = (c < 4);
      if (exp0) q0.push_back({32'hDEAD_BEEF, 1'b0});
      @(negedge clk);
      check("lock_r0_gnt", {31'b0, r0_gnt}, {31'b0, exp0});
      check("lock_r1_gnt", {31'b0, r1_gnt}, {31'b0, ~exp0});
      $display("lock cycle %0d r0_gnt=%0d r1_gnt=%0d", c, r0_gnt, r1_gnt);
      tick();
    end
    idle();

    // Lock released by a cycle without r0_req: no grant, then r1 preferred.
    drive(0, 0, 3'b010, 32'h10, 0);
    r0_lock = 1;
    drive(1, 1, 3'b010, 32'h38, 32'h66);
    q0.push_back({32'hDEAD_BEEF, 1'b0});
    @(negedge clk);
    check("lockrel_c0_r0_gnt", {31'b0, r0_gnt}, 32'd1);
    tick();
    r0_req = 0;
    @(negedge clk);
    check("lockrel_c1_gnt", {30'b0, r1_gnt, r0_gnt}, 32'd0);
    tick();
    r0_req = 1; r0_lock = 0;
    @(negedge clk);
    check("lockrel_c2_gnt", {30'b0, r1_gnt, r0_gnt}, 32'b10);
    tick();
    idle();
    tick();

    // Reset while locked with a response pending.
    drive(0, 0, 3'b010, 32'h10, 0);
    r0_lock = 1;
    @(negedge clk);
    check("rstlock_r0_gnt", {31'b0, r0_gnt}, 32'd1);
    tick();
    check("rstlock_pending", {31'b0, r0_rvalid}, 32'd1);
    reset = 1;
    #1;
    check("rstlock_r0_rvalid", {31'b0, r0_rvalid}, 32'd0);
    check("rstlock_r0_rdata", r0_rdata, 32'd0);
    check("rstlock_r0_err", {31'b0, r0_err}, 32'd0);
    check("rstlock_r0_gnt0", {31'b0, r0_gnt}, 32'd0);
    check("rstlock_mem_wr_en", {31'b0, mem_wr_en}, 32'd0);
    idle();
    tick();
    reset = 0;
    drive(0, 1, 3'b010, 32'h40, 32'h77);
    drive(1, 1, 3'b010, 32'h44, 32'h88);
    @(negedge clk);
    check("post_rst_gnt", {30'b0, r1_gnt, r0_gnt}, 32'b01);
    $display("post-reset r0_gnt=%0d r1_gnt=%0d", r0_gnt, r1_gnt);
    tick();
    idle();

    repeat (3) tick();
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
